// File: rtl/aes_round_tail_if.sv
// aes_round_tail_if: issue-side sideband, SubBytes result and output stream
// of the AES round tail stage.
//
// Handshake semantics: the output stream transfers a word on every clk edge
// where out_valid && out_ready. While out_valid=1 and out_ready=0, out_state
// holds steady. The issue side is credit-style: SubBytes cannot stall, so the
// controller may only raise sb_issue while issue_ready=1.
interface aes_round_tail_if;
  logic         sb_issue;
  logic         issue_ready;
  logic [127:0] round_key;
  logic         final_round;
  logic [127:0] sb_state;
  logic         out_valid;
  logic [127:0] out_state;
  logic         out_ready;

  // Stage side
  modport slave (
    input  sb_issue, round_key, final_round, sb_state, out_ready,
    output issue_ready, out_valid, out_state
  );

  // Round controller / consumer side
  modport master (
    output sb_issue, round_key, final_round, sb_state, out_ready,
    input  issue_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows -> MixColumns (bypassed on the final round) ->
// AddRoundKey on the SubBytes output, buffered in a small output FIFO.
// The key and final-round flag are captured on the issue cycle and used one
// cycle later, when the BRAM SubBytes result arrives.
// Optional debug build: define AES_ROUND_TAIL_DBG_EN to add dbg_overflow
// (sticky issue-while-not-ready flag) and dbg_rounds (FIFO push counter).
module aes_round_tail #(
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  aes_round_tail_if.slave bus
`ifdef AES_ROUND_TAIL_DBG_EN
  ,
  output logic        dbg_overflow,
  output logic [15:0] dbg_rounds
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Byte i of a state lives at bits [127-8i -: 8]; row i%4, column i/4.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Sideband captured on the issue cycle
  logic         pend;
  logic [127:0] key_q;
  logic         fin_q;

  // Output FIFO state
  logic [127:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic         pop, push, accept;
  logic [CW:0]  occ_next;
  logic [127:0] sr_state, round_result;

  // Credit check: occupancy after this edge must leave room for this issue
  always_comb begin
    bus.out_valid = (count != '0);
    bus.out_state = bus.out_valid ? mem[rd_ptr] : '0;
    pop           = bus.out_valid && bus.out_ready;
    occ_next      = {1'b0, count} + (CW + 1)'(pend) - (CW + 1)'(pop);
    bus.issue_ready = (occ_next < (CW + 1)'(FIFO_DEPTH));
    accept        = bus.sb_issue && bus.issue_ready;
    push          = pend && ((count < CW'(FIFO_DEPTH)) || pop);
  end

  // Round datapath from SubBytes output to FIFO write port
  always_comb begin
    sr_state     = shift_rows(bus.sb_state);
    round_result = (fin_q ? sr_state : mix_columns(sr_state)) ^ key_q;
  end

  // Sideband register; a violating issue is never marked pending
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      key_q <= '0;
      fin_q <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        key_q <= bus.round_key;
        fin_q <= bus.final_round;
      end
    end
  end

  // FIFO storage; the head is forced to zero when empty, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= round_result;
    end
  end

  // FIFO pointers and occupancy; full/empty come from count only
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef AES_ROUND_TAIL_DBG_EN
  // Debug: sticky overflow flag and wrapping push counter
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_overflow <= 1'b0;
      dbg_rounds   <= '0;
    end else begin
      if (bus.sb_issue && !bus.issue_ready) begin
        dbg_overflow <= 1'b1;
      end
      if (push) begin
        dbg_rounds <= dbg_rounds + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_tail.sv
// tb_aes_round_tail: directed FIPS-197 vectors plus randomized traffic,
// checked cycle by cycle against a byte-matrix AES reference and an
// expected-output queue.
module tb_aes_round_tail;

  localparam int FIFO_DEPTH = 2;

  logic clk;
  logic rst;

  aes_round_tail_if bus ();

`ifdef AES_ROUND_TAIL_DBG_EN
  logic        dbg_overflow;
  logic [15:0] dbg_rounds;
  aes_round_tail #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_overflow(dbg_overflow), .dbg_rounds(dbg_rounds)
  );
`else
  aes_round_tail #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Scoreboard / reference state
  logic [127:0] exp_q[$];
  bit           m_pend;
  logic [127:0] m_key;
  bit           m_fin;
  logic [127:0] nxt_sb;
  int           m_pushes;
  bit           m_ovf;
  int           n_popped;

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] sb, input logic [127:0] key,
                                             input bit fin);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   m [4][4];
    logic [7:0]   coef [4];
    logic [127:0] o;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i % 4][i / 4] = sb[127 - 8 * i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        m[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) m[r][c] = m[r][c] ^ gf_mul(coef[(k - r + 4) % 4], t[k][c]);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127 - 8 * i -: 8] = (fin ? t[i % 4][i / 4] : m[i % 4][i / 4]) ^ key[127 - 8 * i -: 8];
    return o;
  endfunction

  function automatic bit model_ready(input bit ordy);
    int pop_i;
    pop_i = (exp_q.size() != 0 && ordy) ? 1 : 0;
    return (exp_q.size() + int'(m_pend) - pop_i) < FIFO_DEPTH;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: one clock cycle. sb is the SubBytes value for this cycle's issue,
  // presented on the next cycle. Outputs are scoreboarded 1 ns after negedge.
  task automatic step(input bit issue, input logic [127:0] key, input bit fin,
                      input logic [127:0] sb, input bit ordy, input bit rst_i);
    bit           exp_valid, exp_ready, pop;
    logic [127:0] exp_state;
    @(negedge clk);
    rst             = rst_i;
    bus.sb_issue    = issue;
    bus.round_key   = key;
    bus.final_round = fin;
    bus.sb_state    = nxt_sb;
    bus.out_ready   = ordy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_state = exp_valid ? exp_q[0] : 128'h0;
    pop       = exp_valid && ordy;
    exp_ready = model_ready(ordy);
    if (!rst_i) begin
      n_run++;
      if (bus.out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, exp_valid);
      end
      n_run++;
      if (bus.out_state !== exp_state) begin
        n_fail++;
        $display("FAIL out_state @%0t: got %h expected %h", $time, bus.out_state, exp_state);
      end
      n_run++;
      if (bus.issue_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL issue_ready @%0t: got %b expected %b", $time, bus.issue_ready, exp_ready);
      end
`ifdef AES_ROUND_TAIL_DBG_EN
      n_run++;
      if (dbg_overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL dbg_overflow @%0t: got %b expected %b", $time, dbg_overflow, m_ovf);
      end
      n_run++;
      if (dbg_rounds !== m_pushes[15:0]) begin
        n_fail++;
        $display("FAIL dbg_rounds @%0t: got %0d expected %0d", $time, dbg_rounds, m_pushes[15:0]);
      end
`endif
    end
    // Reference update for the coming clock edge
    if (rst_i) begin
      exp_q.delete();
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_pushes = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_popped++;
      end
      if (m_pend) begin
        exp_q.push_back(ref_round(bus.sb_state, m_key, m_fin));
        m_pushes++;
      end
      if (issue && !exp_ready) m_ovf = 1'b1;
      m_pend = issue && exp_ready;
      if (m_pend) begin
        m_key = key;
        m_fin = fin;
      end
    end
    nxt_sb = sb;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, rand128(), 1'b0, rand128(), ordy, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.out_state !== 128'h0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b s=%h r=%b expected v=0 s=0 r=1",
               bus.out_valid, bus.out_state, bus.issue_ready);
    end
  endtask

  task automatic test_fips_round();
    step(1'b1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
         128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 1'b0);
    idle(1'b1);
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_latency_t1: got out_valid=%b expected 0", bus.out_valid);
    end
    idle(1'b1);
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_fail++;
      $display("FAIL fips_round1: got v=%b %h expected v=1 a49c7ff2689f352b6b5bea43026a5049",
               bus.out_valid, bus.out_state);
    end
    idle(1'b1);
  endtask

  task automatic test_final_round();
    step(1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1,
         128'he9098972cb31075f3d327d94af2e2cb5, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      n_fail++;
      $display("FAIL final_round: got v=%b %h expected v=1 3925841d02dc09fbdc118597196a0b32",
               bus.out_valid, bus.out_state);
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    step(1'b1, rand128(), 1'b1, rand128(), 1'b0, 1'b0);
    idle(1'b0);
    n_run++;
    if (bus.issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_third_issue: got issue_ready=%b expected 0", bus.issue_ready);
    end
    idle(1'b0);
    idle(1'b0);
    n_run++;
    if (bus.issue_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full_hold: got r=%b v=%b expected r=0 v=1", bus.issue_ready, bus.out_valid);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  task automatic test_wrap_full_pushpop();
    int start;
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    idle(1'b0);
    start = n_popped;
    for (int i = 0; i < 40 && (n_popped - start) < 10; i++) begin
      step(model_ready(1'b1), rand128(), $urandom_range(0, 1) == 1, rand128(), 1'b1, 1'b0);
    end
    n_run++;
    if ((n_popped - start) < 10) begin
      n_fail++;
      $display("FAIL wrap_transfers: got %0d expected >= 10", n_popped - start);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  task automatic test_violation();
    logic [127:0] head;
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    idle(1'b0);
    head = exp_q[0];
    step(1'b1, rand128(), 1'b0, rand128(), 1'b0, 1'b0);
    step(1'b1, rand128(), 1'b1, rand128(), 1'b0, 1'b0);
    idle(1'b0);
    n_run++;
    if (bus.out_state !== head) begin
      n_fail++;
      $display("FAIL violation_head: got %h expected %h", bus.out_state, head);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  task automatic test_reset_midflight();
    step(1'b1, rand128(), 1'b0, rand128(), 1'b1, 1'b0);
    step(1'b0, rand128(), 1'b0, rand128(), 1'b1, 1'b1);
    idle(1'b1);
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midflight: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.issue_ready);
    end
    idle(1'b1);
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignore_sb: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    bit ordy, want, issue;
    for (int i = 0; i < 400; i++) begin
      ordy  = $urandom_range(0, 3) != 0;
      want  = $urandom_range(0, 3) != 0;
      issue = want && (model_ready(ordy) || $urandom_range(0, 15) == 0);
      step(issue, rand128(), $urandom_range(0, 1) == 1, rand128(), ordy, 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.sb_issue = 1'b0; bus.round_key = '0; bus.final_round = 1'b0;
    bus.sb_state = '0;   bus.out_ready = 1'b0;
    m_pend = 1'b0; m_key = '0; m_fin = 1'b0; nxt_sb = '0;
    m_pushes = 0; m_ovf = 1'b0; n_popped = 0;
    test_reset();
    test_fips_round();
    test_final_round();
    test_backpressure();
    test_wrap_full_pushpop();
    test_violation();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
